// File: rtl/id_hazard_ctrl_if.sv
// Bus bundle for id_hazard_ctrl: ID/EX hazard inputs, pipeline control outputs
// and performance counters. The master drives the pipeline side, the slave is the controller.
interface id_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_ecall;
    logic             ex_valid;
    logic             ex_mem_read;
    logic [4:0]       ex_rd_addr;
    logic             ex_redirect;
    logic             resume;

    logic             stall_if;
    logic             stall_id;
    logic             flush_if_id;
    logic             bubble_ex;
    logic             halted;
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_ecall, ex_valid, ex_mem_read, ex_rd_addr, ex_redirect, resume,
        input  stall_if, stall_id, flush_if_id, bubble_ex, halted,
               lu_stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_ecall, ex_valid, ex_mem_read, ex_rd_addr, ex_redirect, resume,
        output stall_if, stall_id, flush_if_id, bubble_ex, halted,
               lu_stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, redirect flushes and ecall drain/halt/resume.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module id_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    id_hazard_ctrl_if.slave    bus
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [DW-1:0] drain_cnt_r;
    logic [DW-1:0] drain_cnt_nxt_s;
    logic          lu_s;

    logic          stall_if_s;
    logic          stall_id_s;
    logic          flush_if_id_s;
    logic          bubble_ex_s;
    logic          halted_s;

    // Load-use hazard: EX load writes a nonzero register that ID reads this cycle.
    always_comb begin
        lu_s = bus.id_valid & bus.ex_valid & bus.ex_mem_read &
               (bus.ex_rd_addr != 5'd0) &
               ((bus.id_uses_rs1 & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                (bus.id_uses_rs2 & (bus.id_rs2_addr == bus.ex_rd_addr)));
    end

    // State and drain counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            drain_cnt_r <= {DW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
        end
    end

    // Next-state and pipeline-control decode; reset forces every control output low.
    always_comb begin
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        stall_if_s      = 1'b0;
        stall_id_s      = 1'b0;
        flush_if_id_s   = 1'b0;
        bubble_ex_s     = 1'b0;
        halted_s        = 1'b0;

        if (rst) begin
            state_nxt_s     = RUN;
            drain_cnt_nxt_s = {DW{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (bus.ex_redirect) begin
                        flush_if_id_s = 1'b1;
                        bubble_ex_s   = 1'b1;
                    end else if (lu_s) begin
                        stall_if_s  = 1'b1;
                        stall_id_s  = 1'b1;
                        bubble_ex_s = 1'b1;
                    end else if (bus.id_valid && bus.id_ecall) begin
                        stall_if_s      = 1'b1;
                        stall_id_s      = 1'b1;
                        bubble_ex_s     = 1'b1;
                        drain_cnt_nxt_s = DRAIN_LOAD;
                        state_nxt_s     = DRAIN;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                DRAIN: begin
                    stall_if_s  = 1'b1;
                    stall_id_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                    if (drain_cnt_r == {DW{1'b0}}) begin
                        state_nxt_s = HALT;
                    end else begin
                        drain_cnt_nxt_s = drain_cnt_r - DW'(1);
                    end
                end
                HALT: begin
                    halted_s = 1'b1;
                    // Resume discards the ecall held in ID so the PC moves past it.
                    if (bus.resume) begin
                        flush_if_id_s = 1'b1;
                        bubble_ex_s   = 1'b1;
                        state_nxt_s   = RUN;
                    end else begin
                        stall_if_s  = 1'b1;
                        stall_id_s  = 1'b1;
                        bubble_ex_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s     = RUN;
                    drain_cnt_nxt_s = {DW{1'b0}};
                end
            endcase
        end
    end

    assign bus.stall_if    = stall_if_s;
    assign bus.stall_id    = stall_id_s;
    assign bus.flush_if_id = flush_if_id_s;
    assign bus.bubble_ex   = bubble_ex_s;
    assign bus.halted      = halted_s;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             lu_evt_s;
    logic             flush_evt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : (v + CNT_W'(1));
    endfunction

    assign lu_evt_s    = (state_r == RUN) & ~bus.ex_redirect & lu_s;
    assign flush_evt_s = ((state_r == RUN) & bus.ex_redirect) |
                         ((state_r == HALT) & bus.resume);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_r    <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (lu_evt_s) begin
                lu_cnt_r <= sat_inc(lu_cnt_r);
            end
            if (flush_evt_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign bus.lu_stall_cnt = lu_cnt_r;
    assign bus.flush_cnt    = flush_cnt_r;
`else
    assign bus.lu_stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 3, giving the cycles needed to retire EX/MEM/WB contents after an ecall stalls in ID.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of each performance counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 The block SHALL have port id_valid, input, 1, meaning the IF/ID register holds a valid instruction.
REQ-006 The block SHALL have ports id_rs1_addr and id_rs2_addr, input, 5 each, the decoded source register addresses.
REQ-007 The block SHALL have ports id_uses_rs1 and id_uses_rs2, input, 1 each, meaning the ID instruction reads that source.
REQ-008 The block SHALL have port id_ecall, input, 1, meaning the decoded ID instruction is ECALL.
REQ-009 The block SHALL have ports ex_valid, input, 1; ex_mem_read, input, 1; and ex_rd_addr, input, 5, describing the instruction in EX.
REQ-010 The block SHALL have port ex_redirect, input, 1, meaning a taken branch or jump resolved in EX this cycle.
REQ-011 The block SHALL have port resume, input, 1, a single-cycle pulse releasing the halted core.
REQ-012 The block SHALL have output ports stall_if, stall_id, flush_if_id, bubble_ex, and halted, 1 each.
REQ-013 The block SHALL have output ports lu_stall_cnt and flush_cnt, CNT_W each.

Function
REQ-014 The block SHALL implement FSM states RUN, DRAIN, and HALT, held in a register.
REQ-015 The block SHALL define load-use hazard (lu) = id_valid & ex_valid & ex_mem_read & ex_rd_addr!=0 & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
REQ-016 In RUN with ex_redirect=1, the block SHALL assert flush_if_id=1 and bubble_ex=1 with stall_if=stall_id=0, overriding lu and id_ecall, and SHALL remain in RUN.
REQ-017 In RUN with ex_redirect=0 and lu=1, the block SHALL assert stall_if=stall_id=bubble_ex=1 in the same cycle (combinational, zero latency), stalling exactly one cycle per hazard.
REQ-018 In RUN with ex_redirect=0, lu=0, and id_valid & id_ecall, the block SHALL assert stall_if=stall_id=bubble_ex=1, load the drain counter with DRAIN_CYCLES-1, and enter DRAIN.
REQ-019 In DRAIN, the block SHALL assert stall_if=stall_id=bubble_ex=1, decrement the counter each cycle, and enter HALT on the edge where the counter is 0.
REQ-020 In DRAIN, the block SHALL ignore ex_redirect.
REQ-021 In HALT, the block SHALL assert halted=1 and stall_if=stall_id=bubble_ex=1, and SHALL ignore all inputs except resume.
REQ-022 In HALT with resume=1, the block SHALL assert for that cycle flush_if_id=1, bubble_ex=1, and stall_if=0 so that the ecall is discarded and the PC advances, then enter RUN.
REQ-023 In DRAIN or RUN, the block SHALL ignore resume.
REQ-024 In RUN with no redirect, lu, or ecall, the block SHALL drive all stall, flush, and bubble outputs to 0.

Reset
REQ-025 On a rising edge with rst=1, the block SHALL set state=RUN, drain counter=0, lu_stall_cnt=0, and flush_cnt=0; reset SHALL take priority over every other event, including mid-DRAIN and HALT.
REQ-026 While rst=1, the block SHALL force stall_if, stall_id, flush_if_id, bubble_ex, and halted to 0.

Configuration
REQ-027 With macro HAZARD_PERF_CNT_EN defined, lu_stall_cnt SHALL increment on every cycle of the REQ-017 condition and flush_cnt SHALL increment on every cycle of REQ-016 or REQ-022, each saturating at all-ones.
REQ-028 With HAZARD_PERF_CNT_EN undefined, the block SHALL drive lu_stall_cnt and flush_cnt constant 0 and SHALL contain no counter registers.

Verification
REQ-029 Load-use: ex load rd=5, ID rs2=5 uses_rs2=1 -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle; lu_stall_cnt 0->1 (with EN).
REQ-030 x0 and no-use: ex load rd=0, ID rs1=0; then rd=7 with uses_rs1=0 and rs1=7 -> no stall in either case.
REQ-031 Redirect beats load-use and ecall: ex_redirect=1, lu=1, and id_ecall=1 in the same cycle -> flush_if_id=1, bubble_ex=1, stall_if=0, state stays RUN; flush_cnt +1.
REQ-032 Ecall with DRAIN_CYCLES=3 -> 3 cycles in DRAIN, then halted=1; resume 5 cycles later -> one cycle of flush_if_id=1 and stall_if=0, then RUN with all outputs 0.
REQ-033 Reset mid-DRAIN: rst=1 on DRAIN cycle 2 -> next cycle state RUN, halted=0, counters 0; resume pulse in RUN -> no effect.
REQ-034 Saturation: force lu_stall_cnt to all-ones, then trigger lu -> count holds at all-ones.
